key_status_writer: RTL and testbench
====================================

KEY_STATUS_WRITER -- requirements
Module: key_status_writer

Interface
REQ-001 clk  in  1  sole clock; all logic on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 ev_valid  in  1  note event offered.
REQ-004 ev_ready  out  1  event accepted on the cycle where ev_valid & ev_ready.
REQ-005 ev_on  in  1  1 = note on (set bit), 0 = note off (clear bit).
REQ-006 ev_is_drum  in  1  event targets drum entry (address 48).
REQ-007 ev_inst  in  3  instrument index; bit select for melodic events.
REQ-008 ev_key  in  6  melodic track index, legal 0..47.
REQ-009 ev_drum_key  in  3  bit select for drum events.
REQ-010 clear_req  in  1  request to zero all 49 entries.
REQ-011 wr_addr  out  6  status-memory write address, 0..48.
REQ-012 wr_data  out  8  status-memory write data, bit i = instrument/drum i sounding.
REQ-013 wr_en  out  1  one-cycle pulse marking a new write.
REQ-014 busy  out  1  clear sweep or RMW in progress.
REQ-015 err_range  out  1  one-cycle pulse: melodic event with ev_key > 47 was dropped.
REQ-016 active_notes  out  9  total set bits across all entries, 0..392.

Function
REQ-017 The block SHALL keep an internal 49x8 shadow copy; the shadow is authoritative and the downstream memory mirrors it.
REQ-018 The downstream memory writes every cycle with no enable, so wr_addr/wr_data SHALL always form a consistent pair (address, current shadow content); when idle they hold the last written pair.
REQ-019 FSM states: CLEAR, IDLE, READ, WRITE.
REQ-020 ev_ready SHALL be 1 only in IDLE with clear_req = 0.
REQ-021 IDLE: clear_req=1 -> CLEAR (priority over a simultaneous ev_valid, which is not accepted); accepted legal event -> READ; accepted illegal event -> err_range pulse next cycle, stay IDLE, no write.
REQ-022 Target: drum -> address 48, bit ev_drum_key (ev_inst ignored); melodic -> address ev_key, bit ev_inst.
REQ-023 READ: latch shadow entry; -> WRITE.
REQ-024 WRITE: new = old with target bit set (on) or cleared (off); update shadow, drive wr_addr/wr_data, wr_en = 1; -> IDLE.
REQ-025 Latency: event accepted in cycle N -> wr_en, wr_addr, wr_data registered and valid in cycle N+2; next acceptance no earlier than N+3.
REQ-026 Redundant on (bit already set) or off (bit already clear) SHALL still write (identical data) and SHALL NOT change active_notes.
REQ-027 active_notes SHALL increment by 1 on a 0->1 bit change and decrement by 1 on a 1->0 bit change, updating in the same cycle as wr_en; it never wraps.
REQ-028 CLEAR: write 0 to addresses 0..48 in ascending order, one per cycle, wr_en = 1 each cycle (49 cycles); zero shadow; active_notes = 0 from the first sweep cycle; -> IDLE after address 48.
REQ-029 clear_req during READ/WRITE SHALL be held off until IDLE; clear_req during CLEAR SHALL be ignored (no restart).
REQ-030 busy = 1 in CLEAR, READ, WRITE; 0 in IDLE.

Reset
REQ-031 While rst_n = 0: wr_addr = 0, wr_data = 0, wr_en = 0, ev_ready = 0, busy = 1, err_range = 0, active_notes = 0, state = CLEAR with sweep address 0.
REQ-032 After rst_n rises, the CLEAR sweep SHALL run automatically (first write cycle is the first cycle with rst_n = 1); reset mid-RMW or mid-sweep discards the operation and restarts the sweep from address 0.

Structure
REQ-033 Package key_status_pkg SHALL hold NUM_TRACKS = 48, DRUM_ADDR = 48, NUM_ENTRIES = 49, ADDR_W = 6, and the FSM state enum.
REQ-034 The shadow store SHALL be one sub-module key_status_shadow_ram (49x8, one synchronous read port, one write port).

Verification
REQ-035 Reset release -> 49 consecutive wr_en pulses, addr 0..48, data 0x00, then busy = 0, ev_ready = 1.
REQ-036 On, key 5, inst 3, accepted cycle N -> cycle N+2: wr_addr = 5, wr_data = 0x08, active_notes = 1; then on, key 5, inst 0 -> wr_data = 0x09, active_notes = 2.
REQ-037 Drum on, drum_key 7, inst 2 -> wr_addr = 48, wr_data = 0x80; repeating the event -> same write, active_notes unchanged; off -> 0x00, count decremented.
REQ-038 Melodic event with ev_key = 50 -> err_range pulse, no wr_en, active_notes unchanged.
REQ-039 clear_req and ev_valid asserted together in IDLE -> event not accepted, full sweep, active_notes = 0, event then accepted after the sweep.
REQ-040 rst_n dropped in WRITE with active_notes = 3 -> all outputs at reset values; sweep restarts from address 0.

Source files
------------

// File: rtl/key_status_pkg.sv
// Shared constants, FSM state type and bit-update helper for the key status writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_status_pkg;

    localparam int NUM_TRACKS  = 48;
    localparam int DRUM_ADDR   = 48;
    localparam int NUM_ENTRIES = 49;
    localparam int ADDR_W      = 6;
    localparam int DATA_W      = 8;
    localparam int SEL_W       = 3;
    localparam int CNT_W       = 9;

    localparam logic [ADDR_W-1:0] DRUM_ADDR_V  = ADDR_W'(DRUM_ADDR);
    localparam logic [ADDR_W-1:0] TRACK_LIMIT  = ADDR_W'(NUM_TRACKS);
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(NUM_ENTRIES - 1);
    localparam logic [ADDR_W-1:0] ENTRY_LIMIT  = ADDR_W'(NUM_ENTRIES);
    localparam logic [CNT_W-1:0]  MAX_NOTES    = CNT_W'(NUM_ENTRIES * DATA_W);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Set or clear one bit of a status byte.
    function automatic logic [DATA_W-1:0] apply_bit(
        input logic [DATA_W-1:0] old_val,
        input logic [SEL_W-1:0]  sel,
        input logic              set_bit
    );
        logic [DATA_W-1:0] mask;
        mask = DATA_W'(1) << sel;
        return set_bit ? (old_val | mask) : (old_val & ~mask);
    endfunction

endpackage

// File: rtl/key_status_shadow_ram.sv
// 49x8 shadow store: one synchronous read port, one write port.
// Latency: read data valid the cycle after the address is presented.
// Backpressure: none; read and write every cycle.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_raddr read address; o_rdata registered read data.
module key_status_shadow_ram
    import key_status_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [NUM_ENTRIES];
    logic [DATA_W-1:0] r_rdata;

    // Content needs no reset: every entry is zeroed by the post-reset sweep.
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr < ENTRY_LIMIT)) begin
            r_mem[i_waddr] <= i_wdata;
        end
        // Addresses beyond the table (illegal melodic keys) read as zero.
        if (i_raddr < ENTRY_LIMIT) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/key_status_writer.sv
// Note-event to key-status writer: read-modify-write of a 49x8 shadow, mirrored to a downstream memory.
// Latency: event accepted in cycle N -> write pair presented in cycle N+2; sweep is 49 cycles.
// Backpressure: ev_ready only in IDLE with no clear pending; clear waits for an RMW to finish.
// Ports: clk, rst_n (sync, active-low); ev_* event handshake and fields; clear_req;
//        wr_addr/wr_data/wr_en downstream write; busy; err_range drop pulse; active_notes count.
module key_status_writer
    import key_status_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic              ev_on,
    input  logic              ev_is_drum,
    input  logic [SEL_W-1:0]  ev_inst,
    input  logic [ADDR_W-1:0] ev_key,
    input  logic [SEL_W-1:0]  ev_drum_key,
    input  logic              clear_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              err_range,
    output logic [CNT_W-1:0]  active_notes
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_clr_addr;
    logic [ADDR_W-1:0]  r_tgt_addr;
    logic [SEL_W-1:0]   r_tgt_bit;
    logic               r_tgt_on;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic               r_err;
    logic [CNT_W-1:0]   r_active;

    logic               w_accept;
    logic               w_ev_legal;
    logic [ADDR_W-1:0]  w_tgt_addr;
    logic [SEL_W-1:0]   w_tgt_bit;
    logic [DATA_W-1:0]  w_ram_rdata;
    logic [DATA_W-1:0]  w_new_data;
    logic               w_old_bit;
    logic               w_ram_we;

    assign w_ev_legal = ev_is_drum || (ev_key < TRACK_LIMIT);
    assign w_tgt_addr = ev_is_drum ? DRUM_ADDR_V : ev_key;
    assign w_tgt_bit  = ev_is_drum ? ev_drum_key : ev_inst;

    assign ev_ready = rst_n && (r_state == ST_IDLE) && !clear_req;
    assign w_accept = ev_valid && ev_ready;

    // The read address follows the live event fields, so the entry is already
    // registered at the RAM output when the FSM reaches READ.
    key_status_shadow_ram u_shadow (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (w_tgt_addr),
        .o_rdata (w_ram_rdata)
    );

    assign w_old_bit  = w_ram_rdata[r_tgt_bit];
    assign w_new_data = apply_bit(w_ram_rdata, r_tgt_bit, r_tgt_on);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_addr == LAST_ADDR) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = ST_CLEAR;
                end else if (w_accept && w_ev_legal) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ:  w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_tgt_addr <= '0;
            r_tgt_bit  <= '0;
            r_tgt_on   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_err      <= 1'b0;
            r_active   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_accept && !w_ev_legal;
            case (r_state)
                ST_CLEAR: begin
                    // Keep the held pair in step so IDLE shows the last swept entry.
                    r_wr_addr  <= r_clr_addr;
                    r_wr_data  <= '0;
                    r_active   <= '0;
                    r_clr_addr <= (r_clr_addr == LAST_ADDR) ? '0 : r_clr_addr + 1'b1;
                end
                ST_IDLE: begin
                    // Zero the count on entry so it reads 0 from the first sweep cycle.
                    if (clear_req) begin
                        r_active <= '0;
                    end
                    if (w_accept && w_ev_legal) begin
                        r_tgt_addr <= w_tgt_addr;
                        r_tgt_bit  <= w_tgt_bit;
                        r_tgt_on   <= ev_on;
                    end
                end
                ST_READ: begin
                    r_wr_addr <= r_tgt_addr;
                    r_wr_data <= w_new_data;
                    // Only real bit transitions move the count; redundant events still write.
                    if (r_tgt_on && !w_old_bit && (r_active != MAX_NOTES)) begin
                        r_active <= r_active + 1'b1;
                    end else if (!r_tgt_on && w_old_bit && (r_active != '0)) begin
                        r_active <= r_active - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gating with rst_n keeps wr_en low while held in reset even though the
    // state register already sits in CLEAR, so the sweep's first write lands
    // exactly on the first cycle out of reset.
    assign wr_en    = rst_n && ((r_state == ST_CLEAR) || (r_state == ST_WRITE));
    assign wr_addr  = (r_state == ST_CLEAR) ? r_clr_addr : r_wr_addr;
    assign wr_data  = (r_state == ST_CLEAR) ? '0 : r_wr_data;
    assign w_ram_we = wr_en;

    assign busy         = (r_state != ST_IDLE);
    assign err_range    = r_err;
    assign active_notes = r_active;

endmodule

// File: tb/tb_key_status_writer.sv
// Randomised scoreboard bench for key_status_writer against an array-based reference model.
// Latency: expectations carry the exact cycle in which each write or error pulse must appear.
// Backpressure: driver holds ev_valid until ev_ready is seen, within a cycle bound.
module tb_key_status_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ev_valid = 1'b0;
    logic       ev_ready;
    logic       ev_on = 1'b0;
    logic       ev_is_drum = 1'b0;
    logic [2:0] ev_inst = '0;
    logic [5:0] ev_key = '0;
    logic [2:0] ev_drum_key = '0;
    logic       clear_req = 1'b0;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       busy;
    logic       err_range;
    logic [8:0] active_notes;

    key_status_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_is_drum   (ev_is_drum),
        .ev_inst      (ev_inst),
        .ev_key       (ev_key),
        .ev_drum_key  (ev_drum_key),
        .clear_req    (clear_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .busy         (busy),
        .err_range    (err_range),
        .active_notes (active_notes)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit   is_err;
        int   addr;
        int   data;
        int   cnt;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   shadow[49];
    int   n_chk = 0;
    int   n_pass = 0;
    int   last_acc = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp_v, exp_v, cyc);
    endtask

    function automatic int model_count();
        int s = 0;
        for (int i = 0; i < 49; i++) s += $countones(shadow[i]);
        return s;
    endfunction

    // Expected consequence of the event currently on the ev_* inputs, accepted in cycle n.
    task automatic model_push(input int n);
        exp_t e;
        int   a;
        int   b;
        if (!ev_is_drum && (int'(ev_key) > 47)) begin
            e = '{1'b1, 0, 0, model_count(), n + 1};
        end else begin
            a = ev_is_drum ? 48 : int'(ev_key);
            b = ev_is_drum ? int'(ev_drum_key) : int'(ev_inst);
            if (ev_on) shadow[a] = shadow[a] | (1 << b);
            else       shadow[a] = shadow[a] & ~(1 << b);
            e = '{1'b0, a, shadow[a], model_count(), n + 2};
        end
        exp_q.push_back(e);
    endtask

    task automatic push_sweep(input int start);
        for (int a = 0; a < 49; a++) begin
            shadow[a] = 0;
            exp_q.push_back('{1'b0, a, 0, 0, start + a});
        end
    endtask

    // Monitor: every wr_en or err_range must match the head of the queue, in the expected cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_chk++;
            $display("FAIL missing_output: nothing seen for addr %0d due in cycle %0d (now %0d)",
                     exp_q[0].addr, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (wr_en === 1'b1 || err_range === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output: wr_en=%0b err_range=%0b addr=%0d at cycle %0d",
                         wr_en, err_range, wr_addr, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("out_cycle", cyc, e.cyc);
                chk("is_err", int'(err_range), int'(e.is_err));
                chk("wr_en", int'(wr_en), int'(!e.is_err));
                if (!e.is_err) begin
                    chk("wr_addr", int'(wr_addr), e.addr);
                    chk("wr_data", int'(wr_data), e.data);
                end
                chk("active_notes", int'(active_notes), e.cnt);
            end
        end
    end

    task automatic wait_accept(input bit expect_it);
        bit got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (ev_ready === 1'b1) begin
                got = 1'b1;
                last_acc = cyc;
                if (expect_it) model_push(cyc);
            end
        end
        if (!got) begin
            n_chk++;
            $display("FAIL accept_timeout: ev_ready never rose at cycle %0d", cyc);
        end
        @(posedge clk); #1;
        ev_valid = 1'b0;
    endtask

    task automatic do_event(input bit on, input bit drum, input int inst, input int key,
                            input int dkey, input bit expect_it);
        @(posedge clk); #1;
        ev_on       = on;
        ev_is_drum  = drum;
        ev_inst     = 3'(inst);
        ev_key      = 6'(key);
        ev_drum_key = 3'(dkey);
        ev_valid    = 1'b1;
        wait_accept(expect_it);
    endtask

    task automatic do_clear();
        repeat (3) @(posedge clk);
        #1 clear_req = 1'b1;
        @(negedge clk);
        chk("ready_low_on_clear", int'(ev_ready), 0);
        push_sweep(cyc + 1);
        @(posedge clk); #1;
        clear_req = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_ev_ready", int'(ev_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_err_range", int'(err_range), 0);
        chk("rst_active_notes", int'(active_notes), 0);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        push_sweep(cyc);
        rst_n = 1'b1;
        repeat (49) @(posedge clk);
        @(negedge clk);
        chk("busy_after_sweep", int'(busy), 0);
        chk("ready_after_sweep", int'(ev_ready), 1);
        chk("held_addr", int'(wr_addr), 48);
        chk("held_data", int'(wr_data), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        for (int i = 0; i < 49; i++) shadow[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        release_reset();

        // Melodic accumulation into one entry.
        do_event(1, 0, 3, 5, 0, 1);
        do_event(1, 0, 0, 5, 0, 1);
        // Drum entry: set, redundant set, clear. ev_inst must be ignored.
        do_event(1, 1, 2, 0, 7, 1);
        do_event(1, 1, 2, 0, 7, 1);
        do_event(0, 1, 5, 0, 7, 1);
        // Out-of-range melodic key is dropped with an error pulse.
        do_event(1, 0, 1, 50, 0, 1);
        do_event(0, 0, 3, 5, 0, 1);

        // Clear requested during READ is held off until IDLE (cycle N+3), sweep from N+4;
        // holding it through the sweep must not restart it.
        do_event(1, 0, 6, 20, 0, 1);
        clear_req = 1'b1;
        push_sweep(last_acc + 4);
        repeat (12) @(posedge clk);
        #1 clear_req = 1'b0;

        // Clear and event together in IDLE: clear wins, event accepted after the sweep.
        do_event(1, 0, 2, 9, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        ev_on = 1'b1; ev_is_drum = 1'b0; ev_inst = 3'd6; ev_key = 6'd7; ev_drum_key = 3'd0;
        ev_valid = 1'b1;
        clear_req = 1'b1;
        @(negedge clk);
        chk("ready_low_clear_wins", int'(ev_ready), 0);
        push_sweep(cyc + 1);
        @(posedge clk); #1;
        clear_req = 1'b0;
        wait_accept(1);

        // Randomised traffic concentrated on a few entries to exercise redundancy.
        for (int i = 0; i < 80; i++) begin
            int key;
            sel = int'($urandom_range(0, 9));
            key = (sel == 0) ? int'($urandom_range(40, 63)) : int'($urandom_range(0, 5));
            do_event(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
                     int'($urandom_range(0, 7)), key, int'($urandom_range(0, 7)), 1);
            if ((i % 25) == 24) do_clear();
        end

        // Reset during WRITE with three notes sounding.
        do_clear();
        do_event(1, 0, 0, 1, 0, 1);
        do_event(1, 0, 1, 2, 0, 1);
        do_event(1, 1, 0, 0, 3, 1);
        do_event(1, 0, 4, 10, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("wr_en_low_in_reset", int'(wr_en), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        release_reset();
        do_event(1, 0, 7, 47, 0, 1);
        do_event(1, 0, 7, 48, 0, 1);

        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
